// File: rtl/uart_rx_os16.sv
// Self-timed 8N1 UART receiver running on sysclk: free-running 16x oversample
// prescaler, 3-sample mid-bit majority vote, registered byte/status/error/busy outputs.
module uart_rx_os16 #(
  parameter int BAUD_DIV = 651
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int              PW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic          rxd_m;
  logic          rxd_s;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  state_t        state;
  logic [3:0]    scnt;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          s7;
  logic          s8;
  logic          vote;

  // NOTE: both synchronizer flops reset to the idle line level, so releasing
  // reset never manufactures a start edge on its own.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Free-running prescaler; never realigned to the start edge.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // The live sample on the scnt = 9 tick serves as the third vote input.
  assign vote = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);

  // scnt holds the index of the tick about to be processed; the START entry
  // tick is index 0, so it leaves scnt at 1.
  // NOTE: all state and outputs here use non-blocking assignments so every
  // register sees pre-edge values of the others, independent of statement order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      s7        <= 1'b0;
      s8        <= 1'b0;
      rx_data   <= '0;
      rx_status <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else if (tick) begin
      if (state != IDLE) begin
        if (scnt == 4'd7) s7 <= rxd_s;
        if (scnt == 4'd8) s8 <= rxd_s;
      end

      unique case (state)
        IDLE: begin
          if (!rxd_s) begin
            state   <= START;
            scnt    <= 4'd1;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd9) begin
            if (vote) begin
              state   <= IDLE;
              scnt    <= '0;
              rx_busy <= 1'b0;
            end else begin
              rx_status <= 1'b0;
            end
          end else if (scnt == 4'd15) begin
            state <= DATA;
            bcnt  <= '0;
          end
        end

        DATA: begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd9) begin
            shreg <= {vote, shreg[7:1]};
          end else if (scnt == 4'd15) begin
            if (bcnt == 3'd7) begin
              state <= STOP;
            end else begin
              bcnt <= bcnt + 3'd1;
            end
          end
        end

        STOP: begin
          scnt <= scnt + 4'd1;
          if (scnt == 4'd9) begin
            // Leave at mid-stop so the next start edge is caught early.
            state   <= IDLE;
            scnt    <= '0;
            bcnt    <= '0;
            rx_busy <= 1'b0;
            if (vote) begin
              rx_data   <= shreg;
              rx_status <= 1'b1;
              frame_err <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16 at BAUD_DIV = 4: directed frames, a frame-level
// expectation queue, and one compare process watching outputs every cycle.
module tb_uart_rx_os16;

  localparam int BAUD_DIV = 4;
  localparam int BIT      = 16 * BAUD_DIV;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       rxd    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       rx_busy;

  uart_rx_os16 #(.BAUD_DIV(BAUD_DIV)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  ev_t    exp_q[$];
  int     total    = 0;
  int     bad      = 0;
  int     n_events = 0;
  int     n_falls  = 0;
  longint cyc      = 0;
  longint rise_cyc = 0;

  always @(posedge sysclk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Byte the receiver must report: a data bit flips only when at least two
  // of its three mid-bit samples are disturbed.
  function automatic logic [7:0] model_byte(input logic [7:0] tx, input int inv_bit,
                                            input logic [2:0] inv_s);
    logic [7:0] r;
    r = tx;
    if (inv_bit >= 0 && inv_bit < 8 && $countones(inv_s) >= 2) r[inv_bit] = ~r[inv_bit];
    return r;
  endfunction

  // Drives one 10-bit frame at 'period' cycles per bit, one level per cycle.
  // inv_s[j] inverts the line for the whole tick window of sample 7+j of data
  // bit inv_bit; that window covers every possible prescaler phase.
  task automatic send_frame(input logic [7:0] tx, input logic stop, input int period,
                            input int inv_bit, input logic [2:0] inv_s, input bit expect_it);
    ev_t e;
    if (expect_it) begin
      e.is_err = !stop;
      e.data   = model_byte(tx, inv_bit, inv_s);
      exp_q.push_back(e);
    end
    for (int c = 0; c < 10 * period; c++) begin
      int   b;
      logic lvl;
      b = c / period;
      if (b == 0)      lvl = 1'b0;
      else if (b == 9) lvl = stop;
      else             lvl = tx[b-1];
      if (inv_bit >= 0 && b == inv_bit + 1)
        for (int s = 0; s < 3; s++)
          if (inv_s[s] && c >= BAUD_DIV * (16 * b + 7 + s) && c < BAUD_DIV * (16 * b + 8 + s))
            lvl = ~lvl;
      rxd = lvl;
      @(negedge sysclk);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic wait_events(input int n);
    int k;
    k = 0;
    while (n_events < n && k < 3000) begin
      @(negedge sysclk);
      k++;
    end
    check("event_count", n_events, n);
  endtask

  // Compare process: every delivered byte or framing error must match the
  // head of the expectation queue; rx_data may move only on a byte delivery.
  initial begin
    logic [7:0] pd;
    logic       ps;
    logic       pf;
    ev_t        e;
    pd = '0; ps = 1'b0; pf = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      if (reset) begin
        pd = rx_data; ps = rx_status; pf = frame_err;
        continue;
      end
      if (rx_status && !ps) begin
        rise_cyc = cyc;
        n_events++;
        check("exp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("byte_kind", e.is_err, 0);
          check("rx_data", rx_data, e.data);
        end
        check("frame_err_clear", frame_err, 0);
        check("busy_low_at_byte", rx_busy, 0);
      end else if (frame_err && !pf) begin
        n_events++;
        check("exp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("err_kind", e.is_err, 1);
        end
        check("err_data_kept", rx_data, pd);
        check("err_status_kept", rx_status, ps);
      end else begin
        check("data_stable", rx_data, pd);
      end
      if (!rx_status && ps) begin
        n_falls++;
        check("busy_at_status_drop", rx_busy, 1);
      end
      pd = rx_data; ps = rx_status; pf = frame_err;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    longint start_c;
    longint lat;
    int     k;
    int     falls0;

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge sysclk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_status", rx_status, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_busy", rx_busy, 0);
    reset = 1'b0;
    idle(20);

    // Single byte and start-edge-to-status latency.
    start_c = cyc;
    send_frame(8'h55, 1'b1, BIT, -1, 3'b000, 1'b1);
    idle(BIT);
    wait_events(1);
    lat = rise_cyc - start_c;
    total++;
    if (!(lat >= 612 && lat <= 619)) begin
      bad++;
      $display("FAIL latency: got %0d cycles want 612..619", lat);
    end
    check("t1_data", rx_data, 8'h55);
    check("t1_ferr", frame_err, 0);

    // Glitch of 3 ticks: busy pulses, outputs untouched.
    rxd = 1'b0;
    repeat (3 * BAUD_DIV) @(negedge sysclk);
    rxd = 1'b1;
    k = 0;
    while (!rx_busy && k < 20) begin @(negedge sysclk); k++; end
    check("glitch_busy_rise", rx_busy, 1);
    k = 0;
    while (rx_busy && k < 100) begin @(negedge sysclk); k++; end
    check("glitch_busy_fall", rx_busy, 0);
    check("glitch_data", rx_data, 8'h55);
    check("glitch_status", rx_status, 1);
    idle(BIT);
    send_frame(8'hA3, 1'b1, BIT, -1, 3'b000, 1'b1);
    idle(BIT);
    wait_events(2);
    check("t2_data", rx_data, 8'hA3);

    // Majority vote on data bit 2.
    check("model_pin_one_sample", model_byte(8'h3C, 2, 3'b010), 8'h3C);
    check("model_pin_three_samples", model_byte(8'h3C, 2, 3'b111), 8'h38);
    send_frame(8'h3C, 1'b1, BIT, 2, 3'b010, 1'b1);
    idle(BIT);
    wait_events(3);
    check("t3_one_sample", rx_data, 8'h3C);
    send_frame(8'h3C, 1'b1, BIT, 2, 3'b111, 1'b1);
    idle(BIT);
    wait_events(4);
    check("t3_three_samples", rx_data, 8'h38);

    // Framing error then recovery.
    send_frame(8'hF0, 1'b0, BIT, -1, 3'b000, 1'b1);
    idle(2 * BIT);
    wait_events(5);
    check("t4_ferr_set", frame_err, 1);
    check("t4_data_kept", rx_data, 8'h38);
    send_frame(8'h0F, 1'b1, BIT, -1, 3'b000, 1'b1);
    idle(BIT);
    wait_events(6);
    check("t4_ferr_clear", frame_err, 0);
    check("t4_data", rx_data, 8'h0F);

    // Back-to-back at ~+3 % baud (62 cycles per bit).
    falls0 = n_falls;
    send_frame(8'h00, 1'b1, 62, -1, 3'b000, 1'b1);
    send_frame(8'hFF, 1'b1, 62, -1, 3'b000, 1'b1);
    send_frame(8'h81, 1'b1, 62, -1, 3'b000, 1'b1);
    idle(2 * BIT);
    wait_events(9);
    check("t5_last", rx_data, 8'h81);
    check("t5_status_drops", n_falls - falls0, 3);

    // Reset during data bit 4 of 0xC5. The tail (bit4..bit7, stop, idle) is
    // re-framed from reset release as a valid frame carrying 0xFE.
    fork
      send_frame(8'hC5, 1'b1, BIT, -1, 3'b000, 1'b0);
      begin
        ev_t e;
        repeat (330) @(negedge sysclk);
        reset = 1'b1;
        #1;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_status", rx_status, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_busy", rx_busy, 0);
        e.is_err = 1'b0;
        e.data   = 8'hFE;
        exp_q.push_back(e);
        @(negedge sysclk);
        reset = 1'b0;
      end
    join
    idle(6 * BIT);
    wait_events(10);
    check("t6_tail", rx_data, 8'hFE);
    send_frame(8'h5A, 1'b1, BIT, -1, 3'b000, 1'b1);
    idle(BIT);
    wait_events(11);
    check("t6_data", rx_data, 8'h5A);
    check("t6_busy_idle", rx_busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
